// File: rtl/lotr_pkg.sv
// Shared ring-controller types: opcode, ring request payload and local-arbiter defaults.
package lotr_pkg;

    typedef logic [2:0] t_opcode;
    localparam t_opcode NO_OP = 3'd0;

    typedef struct packed {
        logic [9:0]  requestor;
        t_opcode     opcode;
        logic [31:0] address;
        logic [31:0] data;
    } t_ring_req;

    localparam int RC_LCL_FIFO_DEPTH = 4;
    localparam int RC_STARVE_MAX     = 8;

endpackage

// File: rtl/rc_req_out_arb_if.sv
// Request-side bus of the RingReqOut arbiter: pass-through input, core push port and ring output.
interface rc_req_out_arb_if;
    import lotr_pkg::*;

    logic        PtValidQ501H;
    logic [9:0]  PtRequestorQ501H;
    t_opcode     PtOpcodeQ501H;
    logic [31:0] PtAddressQ501H;
    logic [31:0] PtDataQ501H;

    logic        C2F_ReqValidQ500H;
    t_opcode     C2F_ReqOpcodeQ500H;
    logic [1:0]  C2F_ReqThreadIDQ500H;
    logic [31:0] C2F_ReqAddressQ500H;
    logic [31:0] C2F_ReqDataQ500H;
    logic        C2F_ReqStall;

    logic        RingReqOutValidQ502H;
    logic [9:0]  RingReqOutRequestorQ502H;
    t_opcode     RingReqOutOpcodeQ502H;
    logic [31:0] RingReqOutAddressQ502H;
    logic [31:0] RingReqOutDataQ502H;
    logic        StarveForceQ502H;

    modport master (
        output PtValidQ501H, PtRequestorQ501H, PtOpcodeQ501H, PtAddressQ501H, PtDataQ501H,
        output C2F_ReqValidQ500H, C2F_ReqOpcodeQ500H, C2F_ReqThreadIDQ500H,
        output C2F_ReqAddressQ500H, C2F_ReqDataQ500H,
        input  C2F_ReqStall,
        input  RingReqOutValidQ502H, RingReqOutRequestorQ502H, RingReqOutOpcodeQ502H,
        input  RingReqOutAddressQ502H, RingReqOutDataQ502H, StarveForceQ502H
    );

    modport slave (
        input  PtValidQ501H, PtRequestorQ501H, PtOpcodeQ501H, PtAddressQ501H, PtDataQ501H,
        input  C2F_ReqValidQ500H, C2F_ReqOpcodeQ500H, C2F_ReqThreadIDQ500H,
        input  C2F_ReqAddressQ500H, C2F_ReqDataQ500H,
        output C2F_ReqStall,
        output RingReqOutValidQ502H, RingReqOutRequestorQ502H, RingReqOutOpcodeQ502H,
        output RingReqOutAddressQ502H, RingReqOutDataQ502H, StarveForceQ502H
    );

endinterface

// File: rtl/rc_req_fifo.sv
// Synchronous FIFO of ring requests with occupancy count; the head is read combinationally.
module rc_req_fifo
    import lotr_pkg::*;
#(
    parameter int DEPTH = RC_LCL_FIFO_DEPTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  t_ring_req     wdata,
    input  logic          pop,
    output t_ring_req     rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    t_ring_req         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push at full is still legal then.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/rc_req_out_arb.sv
// RingReqOut slot scheduler: pass-through traffic vs. buffered local core requests,
// with a one-entry delay slot so a starved local request can steal a single ring slot.
module rc_req_out_arb
    import lotr_pkg::*;
#(
    parameter int FIFO_DEPTH = RC_LCL_FIFO_DEPTH,
    parameter int STARVE_MAX = RC_STARVE_MAX
) (
    input  logic       QClk,
    input  logic       RstQnnnL,
    input  logic [7:0] CoreID,
    rc_req_out_arb_if.slave bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX - 1);

    typedef enum logic {DIRECT, DELAYED} t_state;

    t_state        state, state_nxt;
    t_ring_req     dly_req, dly_nxt;
    logic [SW-1:0] starve_cnt, starve_nxt;

    t_ring_req     pt_req, lcl_req, head;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_full, fifo_empty;
    logic          pop, lcl_win;
    logic          win_valid, force_nxt;
    t_ring_req     win_req;

    logic          out_valid, out_force;
    t_ring_req     out_req;

    assign pt_req  = '{requestor: bus.PtRequestorQ501H, opcode: bus.PtOpcodeQ501H,
                       address: bus.PtAddressQ501H, data: bus.PtDataQ501H};
    assign lcl_req = '{requestor: {CoreID, bus.C2F_ReqThreadIDQ500H},
                       opcode: bus.C2F_ReqOpcodeQ500H,
                       address: bus.C2F_ReqAddressQ500H, data: bus.C2F_ReqDataQ500H};

    rc_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (QClk),
        .rst_n (RstQnnnL),
        .push  (bus.C2F_ReqValidQ500H),
        .wdata (lcl_req),
        .pop   (pop),
        .rdata (head),
        .count (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // One request may already be in flight when the core sees stall, hence DEPTH-1.
    assign bus.C2F_ReqStall = fifo_full || (fifo_cnt == CW'(FIFO_DEPTH - 1));

    always_comb begin
        state_nxt = state;
        dly_nxt   = dly_req;
        pop       = 1'b0;
        lcl_win   = 1'b0;
        win_valid = 1'b0;
        win_req   = '0;
        force_nxt = 1'b0;
        case (state)
            DIRECT: begin
                lcl_win = !fifo_empty && (!bus.PtValidQ501H || starve_cnt == STARVE_LIM);
                if (lcl_win) begin
                    pop       = 1'b1;
                    win_valid = 1'b1;
                    win_req   = head;
                    if (bus.PtValidQ501H) begin
                        dly_nxt   = pt_req;
                        state_nxt = DELAYED;
                        force_nxt = 1'b1;
                    end
                end else if (bus.PtValidQ501H) begin
                    win_valid = 1'b1;
                    win_req   = pt_req;
                end
            end
            DELAYED: begin
                win_valid = 1'b1;
                win_req   = dly_req;
                if (bus.PtValidQ501H) dly_nxt = pt_req;
                else                  state_nxt = DIRECT;
            end
            default: state_nxt = DIRECT;
        endcase

        starve_nxt = starve_cnt;
        if (fifo_empty || lcl_win)        starve_nxt = '0;
        else if (starve_cnt != STARVE_LIM) starve_nxt = starve_cnt + 1'b1;
    end

    always_ff @(posedge QClk) begin
        if (!RstQnnnL) begin
            state      <= DIRECT;
            dly_req    <= '0;
            starve_cnt <= '0;
            out_valid  <= 1'b0;
            out_req    <= '0;
            out_force  <= 1'b0;
        end else begin
            state      <= state_nxt;
            dly_req    <= dly_nxt;
            starve_cnt <= starve_nxt;
            out_valid  <= win_valid;
            out_req    <= win_req;
            out_force  <= force_nxt;
        end
    end

    assign bus.RingReqOutValidQ502H     = out_valid;
    assign bus.RingReqOutRequestorQ502H = out_req.requestor;
    assign bus.RingReqOutOpcodeQ502H    = out_req.opcode;
    assign bus.RingReqOutAddressQ502H   = out_req.address;
    assign bus.RingReqOutDataQ502H      = out_req.data;
    assign bus.StarveForceQ502H         = out_force;

endmodule

// File: tb/tb_rc_req_out_arb.sv
// Bench for rc_req_out_arb: directed scenarios plus random traffic against a queue-based model.
module tb_rc_req_out_arb;
    import lotr_pkg::*;

    localparam int DEPTH = 4;
    localparam int SMAX  = 8;

    logic       QClk = 1'b0;
    logic       RstQnnnL = 1'b0;
    logic [7:0] CoreID = 8'h03;

    rc_req_out_arb_if bus();

    rc_req_out_arb #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .QClk     (QClk),
        .RstQnnnL (RstQnnnL),
        .CoreID   (CoreID),
        .bus      (bus)
    );

    always #5 QClk = ~QClk;

    int errs = 0;
    int checks = 0;

    // Reference model: local queue, delay slot (0 or 1 entries), consecutive-loss count.
    t_ring_req lq[$];
    t_ring_req dq[$];
    int        lost = 0;
    logic      exp_v = 1'b0;
    logic      exp_f = 1'b0;
    t_ring_req exp_r = '0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_pt(input logic v, input logic [31:0] addr);
        bus.PtValidQ501H     = v;
        bus.PtRequestorQ501H = 10'($urandom);
        bus.PtOpcodeQ501H    = t_opcode'($urandom_range(0, 7));
        bus.PtAddressQ501H   = addr;
        bus.PtDataQ501H      = $urandom;
    endtask

    task automatic set_c2f(input logic v, input logic [1:0] tid, input logic [31:0] addr);
        bus.C2F_ReqValidQ500H    = v;
        bus.C2F_ReqOpcodeQ500H   = t_opcode'($urandom_range(0, 7));
        bus.C2F_ReqThreadIDQ500H = tid;
        bus.C2F_ReqAddressQ500H  = addr;
        bus.C2F_ReqDataQ500H     = $urandom;
    endtask

    task automatic model_step();
        t_ring_req pt, o, lr;
        logic ov, of, hd, lw;
        pt = '{bus.PtRequestorQ501H, bus.PtOpcodeQ501H, bus.PtAddressQ501H, bus.PtDataQ501H};
        if (!RstQnnnL) begin
            lq.delete();
            dq.delete();
            lost  = 0;
            exp_v = 1'b0;
            exp_f = 1'b0;
            exp_r = '0;
            return;
        end
        o = '0; ov = 1'b0; of = 1'b0; lw = 1'b0;
        hd = lq.size() > 0;
        if (dq.size() > 0) begin
            o  = dq.pop_front();
            ov = 1'b1;
            if (bus.PtValidQ501H) dq.push_back(pt);
        end else begin
            lw = hd && (!bus.PtValidQ501H || lost >= SMAX - 1);
            if (lw) begin
                o  = lq.pop_front();
                ov = 1'b1;
                if (bus.PtValidQ501H) begin
                    dq.push_back(pt);
                    of = 1'b1;
                end
            end else if (bus.PtValidQ501H) begin
                o  = pt;
                ov = 1'b1;
            end
        end
        if (!hd || lw) lost = 0;
        else if (lost < SMAX - 1) lost++;
        if (bus.C2F_ReqValidQ500H && lq.size() < DEPTH) begin
            lr = '{{CoreID, bus.C2F_ReqThreadIDQ500H}, bus.C2F_ReqOpcodeQ500H,
                   bus.C2F_ReqAddressQ500H, bus.C2F_ReqDataQ500H};
            lq.push_back(lr);
        end
        exp_v = ov;
        exp_f = of;
        exp_r = o;
    endtask

    function automatic t_ring_req dut_out();
        return '{bus.RingReqOutRequestorQ502H, bus.RingReqOutOpcodeQ502H,
                 bus.RingReqOutAddressQ502H, bus.RingReqOutDataQ502H};
    endfunction

    task automatic tick();
        model_step();
        @(posedge QClk);
        #1;
        chk("valid", 128'(bus.RingReqOutValidQ502H), 128'(exp_v));
        chk("req",   128'(dut_out()), 128'(exp_r));
        chk("force", 128'(bus.StarveForceQ502H), 128'(exp_f));
        chk("stall", 128'(bus.C2F_ReqStall), 128'(lq.size() >= DEPTH - 1));
    endtask

    initial begin
        int force_at;
        bit got_force;

        // Reset held with every input active.
        set_pt(1'b1, 32'hdead_0000);
        set_c2f(1'b1, 2'd1, 32'h55);
        RstQnnnL = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 128'(bus.RingReqOutValidQ502H), 128'(0));
        chk("rst_stall", 128'(bus.C2F_ReqStall), 128'(0));
        chk("rst_op",    128'(bus.RingReqOutOpcodeQ502H), 128'(NO_OP));
        RstQnnnL = 1'b1;
        set_pt(1'b0, 32'h0);
        set_c2f(1'b0, 2'd0, 32'h0);
        repeat (2) tick();

        // Idle ring: local request appears two cycles after the push.
        CoreID = 8'h03;
        set_c2f(1'b1, 2'd2, 32'h100);
        tick();
        set_c2f(1'b0, 2'd0, 32'h0);
        tick();
        chk("t2_valid", 128'(bus.RingReqOutValidQ502H), 128'(1));
        chk("t2_reqr",  128'(bus.RingReqOutRequestorQ502H), 128'(10'h00E));
        chk("t2_addr",  128'(bus.RingReqOutAddressQ502H), 128'(32'h100));
        chk("t2_force", 128'(bus.StarveForceQ502H), 128'(0));
        repeat (2) tick();

        // Saturated ring: local forces a slot after STARVE_MAX cycles.
        force_at = -1;
        for (int i = 0; i <= 20; i++) begin
            set_pt(1'b1, 32'h1000 + i);
            set_c2f(i == 0, 2'd1, 32'h200);
            tick();
            if (bus.StarveForceQ502H === 1'b1 && force_at < 0) force_at = i;
        end
        chk("t3_force_at", 128'(force_at), 128'(SMAX));

        // Drain the delay slot, then a pass-through goes straight out again.
        set_c2f(1'b0, 2'd0, 32'h0);
        set_pt(1'b0, 32'h0);
        tick();
        chk("t4_drain", 128'(bus.RingReqOutAddressQ502H), 128'(32'h1000 + 20));
        set_pt(1'b1, 32'h1000 + 21);
        tick();
        chk("t4_direct", 128'(bus.RingReqOutAddressQ502H), 128'(32'h1000 + 21));

        // Stall boundary with the ring saturated.
        for (int i = 0; i < 4; i++) begin
            set_pt(1'b1, 32'h2000 + i);
            set_c2f(1'b1, 2'(i), 32'h300 + i);
            tick();
            if (i == 2) chk("t5_stall3", 128'(bus.C2F_ReqStall), 128'(1));
        end
        set_c2f(1'b0, 2'd0, 32'h0);
        set_pt(1'b1, 32'h2010);
        tick();
        chk("t5_stall4", 128'(bus.C2F_ReqStall), 128'(1));
        chk("t5_count4", 128'(lq.size()), 128'(DEPTH));
        set_pt(1'b0, 32'h0);
        repeat (10) tick();

        // Reset while DELAYED with two locals still queued.
        for (int i = 0; i < 3; i++) begin
            set_pt(1'b1, 32'h3000 + i);
            set_c2f(1'b1, 2'd3, 32'h400 + i);
            tick();
        end
        set_c2f(1'b0, 2'd0, 32'h0);
        got_force = 1'b0;
        for (int i = 0; i < 20 && !got_force; i++) begin
            set_pt(1'b1, 32'h3100 + i);
            tick();
            got_force = bus.StarveForceQ502H;
        end
        chk("t6_reached", 128'(got_force), 128'(1));
        chk("t6_fifo2", 128'(lq.size()), 128'(2));
        RstQnnnL = 1'b0;
        tick();
        chk("t6_rst_valid", 128'(bus.RingReqOutValidQ502H), 128'(0));
        chk("t6_rst_stall", 128'(bus.C2F_ReqStall), 128'(0));
        RstQnnnL = 1'b1;
        set_pt(1'b0, 32'h0);
        repeat (4) begin
            tick();
            chk("t6_no_stale", 128'(bus.RingReqOutValidQ502H), 128'(0));
        end

        // Random traffic, with occasional resets.
        for (int n = 0; n < 600; n++) begin
            CoreID = (n % 97 == 0) ? 8'($urandom) : CoreID;
            set_pt($urandom_range(0, 99) < 70, $urandom);
            set_c2f(($urandom_range(0, 99) < 45) && (lq.size() < DEPTH), 2'($urandom), $urandom);
            RstQnnnL = ($urandom_range(0, 199) != 0);
            tick();
        end
        RstQnnnL = 1'b1;
        set_pt(1'b0, 32'h0);
        set_c2f(1'b0, 2'd0, 32'h0);
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
